// File: rtl/uart_rx_cfg_if.sv
// Bundle of the receiver's serial input, runtime configuration and
// frame-result outputs. The line side (pad/config driver) uses master,
// the receiver uses slave.
interface uart_rx_cfg_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic                  rx_in;
    logic [PRESCALE_W-1:0] prescale;
    logic                  parity_enable;
    logic                  parity_type;
    logic                  two_stop;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  parity_error;
    logic                  stop_error;
    logic                  break_det;

    modport master (
        output rx_in, prescale, parity_enable, parity_type, two_stop,
        input  p_data, data_valid, parity_error, stop_error, break_det
    );

    modport slave (
        input  rx_in, prescale, parity_enable, parity_type, two_stop,
        output p_data, data_valid, parity_error, stop_error, break_det
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop input synchroniser, 3-sample majority
// vote per bit, false-start rejection, parity/stop checking, break detect.
// Configuration is captured at the start edge so mid-frame changes are ignored.
module uart_rx_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_cfg_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t                state_q, state_d;
    logic                  rx_meta_q, rx_s_q;
    logic [5:0]            p_q, p_d;
    logic [5:0]            edge_cnt_q, edge_cnt_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [2:0]            samp_q, samp_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  pen_q, pen_d, ptype_q, ptype_d, two_q, two_d;
    logic                  par_bit_q, par_bit_d, par_err_q, par_err_d;
    logic                  stop_low_q, stop_low_d, stop_first_q, stop_first_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  dv_q, dv_d, pe_q, pe_d, se_q, se_d, bk_q, bk_d;

    logic [5:0] p_sel, half, last_edge;
    logic       vote, decide, wrap;
    logic       serr, first_stop, brk, perr;

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx_in;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Prescale decode (unsupported values fall back to 16) and bit-timing points
    always_comb begin
        if (bus.prescale == PRESCALE_W'(8))       p_sel = 6'd8;
        else if (bus.prescale == PRESCALE_W'(32)) p_sel = 6'd32;
        else                                      p_sel = 6'd16;
        half      = p_q >> 1;
        last_edge = p_q - 6'd1;
        vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
        decide    = (edge_cnt_q == half + 6'd2);
        wrap      = (edge_cnt_q == last_edge);
    end

    // Next-state logic: FSM, bit timing, sampling and frame-end result strobes
    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        edge_cnt_d   = wrap ? 6'd0 : edge_cnt_q + 6'd1;
        bit_cnt_d    = bit_cnt_q;
        samp_d       = samp_q;
        shift_d      = shift_q;
        pen_d        = pen_q;
        ptype_d      = ptype_q;
        two_d        = two_q;
        par_bit_d    = par_bit_q;
        par_err_d    = par_err_q;
        stop_low_d   = stop_low_q;
        stop_first_d = stop_first_q;
        p_data_d     = p_data_q;
        dv_d         = 1'b0;
        pe_d         = 1'b0;
        se_d         = 1'b0;
        bk_d         = 1'b0;
        serr         = 1'b0;
        first_stop   = 1'b1;
        brk          = 1'b0;
        perr         = 1'b0;

        if (edge_cnt_q == half - 6'd1) samp_d[0] = rx_s_q;
        if (edge_cnt_q == half)        samp_d[1] = rx_s_q;
        if (edge_cnt_q == half + 6'd1) samp_d[2] = rx_s_q;

        case (state_q)
            IDLE: begin
                edge_cnt_d = 6'd0;
                bit_cnt_d  = 4'd0;
                stop_low_d = 1'b0;
                par_err_d  = 1'b0;
                par_bit_d  = 1'b0;
                if (!rx_s_q) begin
                    state_d = START;
                    p_d     = p_sel;
                    pen_d   = bus.parity_enable;
                    ptype_d = bus.parity_type;
                    two_d   = bus.two_stop;
                end
            end
            START: begin
                if (decide && vote) begin
                    // Line went back high before mid-bit: treat as a glitch
                    state_d    = IDLE;
                    edge_cnt_d = 6'd0;
                end else if (wrap) begin
                    state_d   = DATA;
                    bit_cnt_d = 4'd0;
                end
            end
            DATA: begin
                if (decide) shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
                if (wrap) begin
                    if (bit_cnt_q == 4'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = 4'd0;
                        state_d   = pen_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (decide) begin
                    par_bit_d = vote;
                    par_err_d = vote ^ (^shift_q) ^ ptype_q;
                end
                if (wrap) begin
                    state_d   = STOP;
                    bit_cnt_d = 4'd0;
                end
            end
            STOP: begin
                if (decide && bit_cnt_q == {3'b000, two_q}) begin
                    // Last stop bit decided: finish the frame without waiting out the bit
                    serr       = stop_low_q | ~vote;
                    first_stop = (bit_cnt_q == 4'd0) ? vote : stop_first_q;
                    brk        = (shift_q == '0) && (!pen_q || !par_bit_q) && !first_stop;
                    perr       = pen_q & par_err_q;
                    p_data_d   = shift_q;
                    dv_d       = ~perr & ~serr;
                    pe_d       = perr & ~brk;
                    se_d       = serr;
                    bk_d       = brk;
                    state_d    = serr ? WAIT_HIGH : IDLE;
                    edge_cnt_d = 6'd0;
                end else begin
                    if (decide) begin
                        stop_first_d = vote;
                        stop_low_d   = stop_low_q | ~vote;
                    end
                    if (wrap) bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            WAIT_HIGH: begin
                edge_cnt_d = 6'd0;
                if (rx_s_q) state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = 6'd0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            p_q          <= 6'd16;
            edge_cnt_q   <= 6'd0;
            bit_cnt_q    <= 4'd0;
            samp_q       <= 3'b111;
            shift_q      <= '0;
            pen_q        <= 1'b0;
            ptype_q      <= 1'b0;
            two_q        <= 1'b0;
            par_bit_q    <= 1'b0;
            par_err_q    <= 1'b0;
            stop_low_q   <= 1'b0;
            stop_first_q <= 1'b1;
            p_data_q     <= '0;
            dv_q         <= 1'b0;
            pe_q         <= 1'b0;
            se_q         <= 1'b0;
            bk_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
            pen_q        <= pen_d;
            ptype_q      <= ptype_d;
            two_q        <= two_d;
            par_bit_q    <= par_bit_d;
            par_err_q    <= par_err_d;
            stop_low_q   <= stop_low_d;
            stop_first_q <= stop_first_d;
            p_data_q     <= p_data_d;
            dv_q         <= dv_d;
            pe_q         <= pe_d;
            se_q         <= se_d;
            bk_q         <= bk_d;
        end
    end

    assign bus.p_data       = p_data_q;
    assign bus.data_valid   = dv_q;
    assign bus.parity_error = pe_q;
    assign bus.stop_error   = se_q;
    assign bus.break_det    = bk_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: frames are serialised onto rx_in,
// their expected results queued, and a negedge monitor pops and compares
// whenever the receiver raises a result strobe.
module tb_uart_rx_cfg;
    localparam int DW = 8;
    localparam int PW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_cfg_if #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) bus();
    uart_rx_cfg #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          dv, pe, se, bk;
    } exp_t;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] prev_strb = 4'b0;

    // Strobe monitor: every strobe cycle must match the oldest queued frame
    always @(negedge clk) begin
        logic [3:0] strb;
        exp_t       e;
        strb = {bus.data_valid, bus.parity_error, bus.stop_error, bus.break_det};
        if (!rst && strb != 4'b0) begin
            n_vec++;
            if ((strb & prev_strb) != 4'b0) begin
                n_err++;
                $display("FAIL strobe_width got=%b prev=%b required one-cycle pulses", strb, prev_strb);
            end
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_strobe got=%b (dv,pe,se,bk) p_data=%h required none", strb, bus.p_data);
            end else begin
                e = sb.pop_front();
                n_vec++;
                if (strb !== {e.dv, e.pe, e.se, e.bk}) begin
                    n_err++;
                    $display("FAIL strobes got=%b required=%b (dv,pe,se,bk)", strb, {e.dv, e.pe, e.se, e.bk});
                end
                n_vec++;
                if (bus.p_data !== e.data) begin
                    n_err++;
                    $display("FAIL p_data got=%h required=%h", bus.p_data, e.data);
                end
                $display("frame t=%0t p_data=%h strobes(dv,pe,se,bk)=%b", $time, bus.p_data, strb);
            end
        end
        prev_strb = strb;
    end

    // Watchdog so a stuck run still ends
    initial begin
        #500000;
        $display("FAIL watchdog timeout pending=%0d required=0", sb.size());
        $fatal(1, "timeout");
    end

    task automatic hold(input logic v, input int n);
        bus.rx_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int p, input logic pen, input logic ptype, input logic two);
        bus.prescale      = PW'(p);
        bus.parity_enable = pen;
        bus.parity_type   = ptype;
        bus.two_stop      = two;
    endtask

    // Serialise one frame with the current config; spike_bit >= 0 inverts
    // that data bit for a single clock at its first sample point.
    task automatic send_frame(input logic [DW-1:0] d, input int p, input logic pen,
                              input logic ptype, input logic two, input logic pbit,
                              input logic s1, input logic s2, input int spike_bit);
        exp_t e;
        logic perr_raw, serr, brk;
        perr_raw = pen && (pbit != ((^d) ^ ptype));
        serr     = !s1 || (two && !s2);
        brk      = (d == '0) && (!pen || !pbit) && !s1;
        e.data = d;
        e.dv   = !perr_raw && !serr;
        e.pe   = perr_raw && !brk;
        e.se   = serr;
        e.bk   = brk;
        sb.push_back(e);
        set_cfg(p, pen, ptype, two);
        hold(1'b0, p);
        for (int k = 0; k < DW; k++) begin
            if (k == spike_bit) begin
                hold(d[k], p / 2);
                hold(~d[k], 1);
                hold(d[k], p - p / 2 - 1);
            end else begin
                hold(d[k], p);
            end
        end
        if (pen) hold(pbit, p);
        hold(s1, p);
        if (two) hold(s2, p);
    endtask

    task automatic drain(input int budget, output bit ok);
        int b;
        b = budget;
        while (sb.size() != 0 && b > 0) begin
            @(negedge clk);
            b--;
        end
        ok = (sb.size() == 0);
        if (!ok) sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.rx_in = 1'b1;
        set_cfg(16, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_vec++;
        if ({bus.p_data, bus.data_valid, bus.parity_error, bus.stop_error, bus.break_det} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got p_data=%h strobes=%b required all 0", bus.p_data,
                     {bus.data_valid, bus.parity_error, bus.stop_error, bus.break_det});
        end
        rst = 1'b0;
        hold(1'b1, 10);
    endtask

    task automatic test_p32_even();
        bit ok;
        send_frame(8'hB4, 32, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        hold(1'b1, 40);
        drain(200, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL p32_even_drain got=missing required=1 frame"); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        send_frame(8'h0F, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, -1);
        send_frame(8'hF0, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, -1);
        hold(1'b1, 20);
        drain(200, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL back_to_back_drain got=missing required=2 frames"); end
    endtask

    task automatic test_parity_error();
        bit ok;
        send_frame(8'hF0, 16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        hold(1'b1, 20);
        drain(200, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL parity_error_drain got=missing required=1 frame"); end
        n_vec++;
        if (bus.p_data !== 8'hF0) begin
            n_err++;
            $display("FAIL parity_error_pdata_hold got=%h required=f0", bus.p_data);
        end
    endtask

    task automatic test_stop_error();
        bit ok;
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        hold(1'b0, 3 * 16);
        hold(1'b1, 32);
        drain(50, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL stop_error_drain got=missing required=1 frame"); end
        send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        hold(1'b1, 20);
        drain(200, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL after_stop_error_drain got=missing required=1 frame"); end
    endtask

    task automatic test_break();
        bit   ok;
        exp_t e;
        e = '{data: 8'h00, dv: 1'b0, pe: 1'b0, se: 1'b1, bk: 1'b1};
        sb.push_back(e);
        set_cfg(32, 1'b1, 1'b0, 1'b0);
        hold(1'b0, 12 * 32);
        hold(1'b1, 64);
        drain(50, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL break_drain got=missing required=1 frame"); end
        send_frame(8'h81, 32, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        hold(1'b1, 40);
        drain(200, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL after_break_drain got=missing required=1 frame"); end
    endtask

    task automatic test_glitch_spike_reset();
        bit         ok;
        logic [7:0] d;
        set_cfg(16, 1'b0, 1'b0, 1'b0);
        hold(1'b0, 4);
        hold(1'b1, 60);
        n_vec++;
        if (bus.p_data !== 8'h81) begin
            n_err++;
            $display("FAIL glitch_pdata got=%h required=81", bus.p_data);
        end
        send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3);
        hold(1'b1, 20);
        drain(200, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL spike_drain got=missing required=1 frame"); end
        // Partial frame aborted by reset at data bit 5
        d = 8'h3C;
        hold(1'b0, 16);
        for (int k = 0; k < 5; k++) hold(d[k], 16);
        rst       = 1'b1;
        bus.rx_in = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({bus.p_data, bus.data_valid, bus.parity_error, bus.stop_error, bus.break_det} !== '0) begin
            n_err++;
            $display("FAIL midframe_reset got p_data=%h strobes=%b required all 0", bus.p_data,
                     {bus.data_valid, bus.parity_error, bus.stop_error, bus.break_det});
        end
        rst = 1'b0;
        hold(1'b1, 16 * 8);
        n_vec++;
        if (bus.p_data !== 8'h00) begin
            n_err++;
            $display("FAIL after_reset_pdata got=%h required=00", bus.p_data);
        end
    endtask

    initial begin
        test_reset();
        test_p32_even();
        test_back_to_back();
        test_parity_error();
        test_stop_error();
        test_break();
        test_glitch_spike_reset();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expected got=%0d required=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
